// File: rtl/issue_ctrl_pkg.sv
// Opcode constants, scheduler FSM states and RV field extraction / classification helpers.
package issue_ctrl_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SETTLE} state_t;

  function automatic logic [4:0] f_rd(input logic [31:0] ins);
    return ins[11:7];
  endfunction

  function automatic logic [4:0] f_rs1(input logic [31:0] ins);
    return ins[19:15];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] ins);
    return ins[24:20];
  endfunction

  function automatic logic f_has_rd(input logic [31:0] ins);
    return !(ins[6:0] inside {OPC_STORE, OPC_BRANCH, OPC_MISC_MEM});
  endfunction

  function automatic logic f_uses_rs1(input logic [31:0] ins);
    return !(ins[6:0] inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  endfunction

  function automatic logic f_uses_rs2(input logic [31:0] ins);
    return ins[6:0] inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  endfunction

  function automatic logic f_serial(input logic [31:0] ins);
    return ins[6:0] inside {OPC_SYSTEM, OPC_MISC_MEM};
  endfunction

  function automatic logic f_ctrl(input logic [31:0] ins);
    return ins[6:0] inside {OPC_BRANCH, OPC_JAL, OPC_JALR};
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy bits: issue sets, writeback clears (set wins), flush clears all; 1-cycle update.
// ISSUE_WB_BYPASS_EN: busy/any_busy already hide same-cycle writeback clears.
module issue_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int NUM_REG = 32
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               flush,
  input  logic [NUM_REG-1:1] set_vec,
  input  logic [NUM_REG-1:1] clr_vec,
  output logic [NUM_REG-1:1] busy,
  output logic               any_busy
);

  logic [NUM_REG-1:1] busy_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_vec) | set_vec;
    end
  end

`ifdef ISSUE_WB_BYPASS_EN
  assign busy = busy_q & ~clr_vec;
`else
  assign busy = busy_q;
`endif

  assign any_busy = |busy;

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: issue/pop are combinational; scoreboard, FSM and stall counter update on clock.
// Holds issue on idReady low, hazards or serialisation; ISSUE_WB_BYPASS_EN lets writebacks unblock same cycle.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int  XLEN    = 32,
  parameter int  NUM_REG = 32,
  localparam int RIDX    = $clog2(NUM_REG)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            flush,
  input  logic            queueEmpty,
  input  logic            queueOne,
  input  logic [31:0]     insA,
  input  logic [31:0]     insB,
  input  logic            idReady,
  input  logic            wbA_en,
  input  logic            wbB_en,
  input  logic [RIDX-1:0] wbA_rd,
  input  logic [RIDX-1:0] wbB_rd,
  output logic [1:0]      pop,
  output logic            issueA,
  output logic            issueB,
  output logic [31:0]     stallCycles
);

  if ((XLEN != 32 && XLEN != 64) || (NUM_REG != 16 && NUM_REG != 32)) begin : g_bad_cfg
    $error("issue_ctrl: unsupported XLEN or NUM_REG");
  end

  state_t             state;
  logic [31:0]        stall_q;
  logic [RIDX-1:0]    a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
  logic               a_has_rd, a_rs1_use, a_rs2_use, a_serial, a_ctrl;
  logic               b_has_rd, b_rs1_use, b_rs2_use, b_serial;
  logic [NUM_REG-1:1] busy, set_vec, clr_vec;
  logic [NUM_REG-1:0] busy_x;
  logic               any_busy, haz_a, haz_b, dep_b, can_go, issue_a, issue_b;

  assign a_rd      = RIDX'(f_rd(insA));
  assign a_rs1     = RIDX'(f_rs1(insA));
  assign a_rs2     = RIDX'(f_rs2(insA));
  assign a_has_rd  = f_has_rd(insA);
  assign a_rs1_use = f_uses_rs1(insA);
  assign a_rs2_use = f_uses_rs2(insA);
  assign a_serial  = f_serial(insA);
  assign a_ctrl    = f_ctrl(insA);
  assign b_rd      = RIDX'(f_rd(insB));
  assign b_rs1     = RIDX'(f_rs1(insB));
  assign b_rs2     = RIDX'(f_rs2(insB));
  assign b_has_rd  = f_has_rd(insB);
  assign b_rs1_use = f_uses_rs1(insB);
  assign b_rs2_use = f_uses_rs2(insB);
  assign b_serial  = f_serial(insB);

  // x0 reads as never busy, so it needs no special case in the hazard terms
  assign busy_x = {busy, 1'b0};
  assign haz_a  = (a_rs1_use & busy_x[a_rs1]) | (a_rs2_use & busy_x[a_rs2]) | (a_has_rd & busy_x[a_rd]);
  assign haz_b  = (b_rs1_use & busy_x[b_rs1]) | (b_rs2_use & busy_x[b_rs2]) | (b_has_rd & busy_x[b_rd]);
  assign dep_b  = a_has_rd & (a_rd != '0) &
                  ((b_rs1_use & (b_rs1 == a_rd)) | (b_rs2_use & (b_rs2 == a_rd)) | (b_has_rd & (b_rd == a_rd)));

  // resetn gates issue so a reset asserted mid-cycle drops pop immediately
  assign can_go = resetn & !flush & !queueEmpty & idReady;

  always_comb begin
    issue_a = 1'b0;
    issue_b = 1'b0;
    case (state)
      ST_RUN: begin
        if (a_serial) begin
          issue_a = can_go & !any_busy;
        end else begin
          issue_a = can_go & !haz_a;
          issue_b = issue_a & !queueOne & !b_serial & !a_ctrl & !haz_b & !dep_b;
        end
      end
      ST_DRAIN: issue_a = can_go & !any_busy;
      default: ;
    endcase
  end

  assign issueA      = issue_a;
  assign issueB      = issue_b;
  assign pop         = {1'b0, issue_a} + {1'b0, issue_b};
  assign stallCycles = stall_q;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int r = 1; r < NUM_REG; r++) begin
      set_vec[r] = (issue_a & a_has_rd & (a_rd == RIDX'(r))) | (issue_b & b_has_rd & (b_rd == RIDX'(r)));
      clr_vec[r] = (wbA_en & (wbA_rd == RIDX'(r))) | (wbB_en & (wbB_rd == RIDX'(r)));
    end
  end

  issue_scoreboard #(.NUM_REG(NUM_REG)) u_sb (
    .clock    (clock),
    .resetn   (resetn),
    .flush    (flush),
    .set_vec  (set_vec),
    .clr_vec  (clr_vec),
    .busy     (busy),
    .any_busy (any_busy)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_RUN;
      stall_q <= '0;
    end else begin
      if (!flush && !queueEmpty && pop == 2'd0 && stall_q != 32'hFFFF_FFFF) begin
        stall_q <= stall_q + 32'd1;
      end
      if (flush) begin
        state <= ST_RUN;
      end else begin
        case (state)
          ST_RUN:    if (!queueEmpty && a_serial) state <= issue_a ? ST_SETTLE : ST_DRAIN;
          ST_DRAIN:  if (issue_a) state <= ST_SETTLE;
          ST_SETTLE: if (!any_busy) state <= ST_RUN;
          default:   state <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: behavioural scoreboard/serialisation model checked every negedge,
// plus literal expectations at the key points of each scenario.
module tb_issue_ctrl;

  localparam int NUM_REG = 32;
`ifdef ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [6:0] M_OP = 7'h33, M_ST = 7'h23, M_BR = 7'h63, M_JAL = 7'h6F, M_JALR = 7'h67;
  localparam logic [6:0] M_LUI = 7'h37, M_AUIPC = 7'h17, M_SYS = 7'h73, M_FENCE = 7'h0F;
  localparam logic [31:0] FENCE_I = 32'h0FF0_000F;
  localparam logic [31:0] ECALL_I = 32'h0000_0073;

  logic        clock = 1'b0, resetn = 1'b0, flush = 1'b0, queueEmpty = 1'b1, queueOne = 1'b0;
  logic        idReady = 1'b0, wbA_en = 1'b0, wbB_en = 1'b0;
  logic [31:0] insA = '0, insB = '0;
  logic [4:0]  wbA_rd = '0, wbB_rd = '0;
  logic [1:0]  pop;
  logic        issueA, issueB;
  logic [31:0] stallCycles;

  issue_ctrl #(.XLEN(32), .NUM_REG(NUM_REG)) dut (
    .clock(clock), .resetn(resetn), .flush(flush), .queueEmpty(queueEmpty), .queueOne(queueOne),
    .insA(insA), .insB(insB), .idReady(idReady), .wbA_en(wbA_en), .wbB_en(wbB_en),
    .wbA_rd(wbA_rd), .wbB_rd(wbB_rd), .pop(pop), .issueA(issueA), .issueB(issueB),
    .stallCycles(stallCycles)
  );

  always #5 clock = ~clock;

  // Model state: which registers have an outstanding writer, and serialisation phase.
  bit          m_busy [NUM_REG];
  bit          m_waiting = 1'b0;
  bit          m_settling = 1'b0;
  logic [31:0] m_stall = '0;
  int          n_chk = 0, n_fail = 0;
  bit          u_ia, u_ib, u_empty, u_set, u_clr, c_ia, c_ib;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] add_i(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), M_OP};
  endfunction
  function automatic logic [31:0] beq_i(input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'd0, M_BR};
  endfunction
  function automatic logic [31:0] csrrw_i(input int rd, input int rs1);
    return {12'h340, 5'(rs1), 3'b001, 5'(rd), M_SYS};
  endfunction

  function automatic bit writes(input logic [31:0] i);
    return !(i[6:0] == M_ST || i[6:0] == M_BR || i[6:0] == M_FENCE);
  endfunction
  function automatic bit reads1(input logic [31:0] i);
    return !(i[6:0] == M_LUI || i[6:0] == M_AUIPC || i[6:0] == M_JAL);
  endfunction
  function automatic bit reads2(input logic [31:0] i);
    return i[6:0] == M_OP || i[6:0] == M_ST || i[6:0] == M_BR;
  endfunction
  function automatic bit is_serial(input logic [31:0] i);
    return i[6:0] == M_SYS || i[6:0] == M_FENCE;
  endfunction
  function automatic bit is_ctrl(input logic [31:0] i);
    return i[6:0] == M_BR || i[6:0] == M_JAL || i[6:0] == M_JALR;
  endfunction

  function automatic bit wb_hits(input int r);
    return (wbA_en && int'(wbA_rd) == r) || (wbB_en && int'(wbB_rd) == r);
  endfunction
  function automatic bit seen_busy(input int r);
    if (r == 0) return 1'b0;
    if (BYP && wb_hits(r)) return 1'b0;
    return m_busy[r];
  endfunction
  function automatic bit nothing_busy();
    for (int r = 1; r < NUM_REG; r++) if (seen_busy(r)) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit blocked(input logic [31:0] i);
    return (reads1(i) && seen_busy(int'(i[19:15]))) || (reads2(i) && seen_busy(int'(i[24:20])))
        || (writes(i) && seen_busy(int'(i[11:7])));
  endfunction
  function automatic bit b_needs_a();
    if (!writes(insA) || insA[11:7] == 5'd0) return 1'b0;
    return (reads1(insB) && insB[19:15] == insA[11:7]) || (reads2(insB) && insB[24:20] == insA[11:7])
        || (writes(insB) && insB[11:7] == insA[11:7]);
  endfunction

  function automatic void expect_issue(output bit ia, output bit ib);
    ia = 1'b0;
    ib = 1'b0;
    if (!resetn || flush || queueEmpty || !idReady || m_settling) return;
    if (m_waiting || is_serial(insA)) begin
      ia = nothing_busy();
      return;
    end
    ia = !blocked(insA);
    ib = ia && !queueOne && !is_serial(insB) && !is_ctrl(insA) && !blocked(insB) && !b_needs_a();
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NUM_REG; r++) m_busy[r] = 1'b0;
      m_waiting = 1'b0;
      m_settling = 1'b0;
      m_stall = '0;
    end else begin
      expect_issue(u_ia, u_ib);
      u_empty = nothing_busy();
      if (!flush && !queueEmpty && !u_ia && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (flush) begin
        for (int r = 0; r < NUM_REG; r++) m_busy[r] = 1'b0;
        m_waiting = 1'b0;
        m_settling = 1'b0;
      end else begin
        if (m_settling) begin
          if (u_empty) m_settling = 1'b0;
        end else if (m_waiting || (!queueEmpty && is_serial(insA))) begin
          m_waiting  = !u_ia;
          m_settling = u_ia;
        end
        for (int r = 1; r < NUM_REG; r++) begin
          u_set = (u_ia && writes(insA) && int'(insA[11:7]) == r) || (u_ib && writes(insB) && int'(insB[11:7]) == r);
          u_clr = wb_hits(r);
          m_busy[r] = u_set || (m_busy[r] && !u_clr);
        end
      end
    end
  end

  always @(negedge clock) begin
    expect_issue(c_ia, c_ib);
    check("issueA", 32'(issueA), 32'(c_ia));
    check("issueB", 32'(issueB), 32'(c_ib));
    check("pop", 32'(pop), 32'(c_ia) + 32'(c_ib));
    check("stallCycles", stallCycles, m_stall);
  end

  task automatic step(input bit qe, input bit q1, input logic [31:0] a, input logic [31:0] b,
                      input bit rdy, input bit wae, input int wa, input bit wbe, input int wb, input bit fl);
    @(posedge clock);
    #1;
    queueEmpty = qe; queueOne = q1; insA = a; insB = b; idReady = rdy;
    wbA_en = wae; wbA_rd = 5'(wa); wbB_en = wbe; wbB_rd = 5'(wb); flush = fl;
    #2;
  endtask

  initial begin
    queueEmpty = 1'b0; insA = add_i(1, 2, 3); insB = add_i(4, 5, 6); idReady = 1'b1;
    #3;
    check("reset_pop", 32'(pop), 32'd0);
    check("reset_issueA", 32'(issueA), 32'd0);
    check("reset_stall", stallCycles, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1; queueEmpty = 1'b1;

    step(0, 0, add_i(1, 2, 3), add_i(4, 5, 6), 1, 0, 0, 0, 0, 0);
    check("pair_pop", 32'(pop), 32'd2);
    check("pair_issueB", 32'(issueB), 32'd1);
    step(0, 1, add_i(8, 4, 0), '0, 1, 0, 0, 0, 0, 0);
    check("x4_busy_pop", 32'(pop), 32'd0);
    step(1, 0, '0, '0, 1, 1, 1, 1, 4, 0);

    step(0, 0, add_i(1, 2, 3), add_i(7, 1, 2), 1, 0, 0, 0, 0, 0);
    check("raw_pair_pop", 32'(pop), 32'd1);
    step(0, 1, add_i(7, 1, 2), '0, 1, 0, 0, 0, 0, 0);
    check("raw_wait_pop", 32'(pop), 32'd0);
    step(0, 1, add_i(7, 1, 2), '0, 1, 1, 1, 0, 0, 0);
    check("raw_wb_cycle_pop", 32'(pop), BYP ? 32'd1 : 32'd0);
    step(0, 1, add_i(7, 1, 2), '0, 1, 0, 0, 0, 0, 0);
    check("raw_after_wb_pop", 32'(pop), BYP ? 32'd0 : 32'd1);
    step(1, 0, '0, '0, 1, 1, 7, 0, 0, 0);

    step(0, 0, beq_i(1, 2), add_i(10, 11, 12), 1, 0, 0, 0, 0, 0);
    check("branch_pop", 32'(pop), 32'd1);
    step(0, 1, add_i(11, 12, 13), add_i(14, 15, 16), 1, 0, 0, 0, 0, 0);
    check("one_pop", 32'(pop), 32'd1);
    check("one_issueB", 32'(issueB), 32'd0);
    step(0, 1, add_i(3, 12, 13), '0, 1, 1, 11, 0, 0, 0);

    step(0, 1, csrrw_i(5, 3), '0, 1, 0, 0, 0, 0, 0);
    check("csr_drain_pop", 32'(pop), 32'd0);
    step(0, 1, csrrw_i(5, 3), '0, 1, 0, 0, 0, 0, 0);
    step(0, 1, csrrw_i(5, 3), '0, 1, 1, 3, 0, 0, 0);
    check("csr_wb_cycle_pop", 32'(pop), BYP ? 32'd1 : 32'd0);
    step(0, 1, csrrw_i(5, 3), '0, 1, 0, 0, 0, 0, 0);
    check("csr_after_wb_pop", 32'(pop), BYP ? 32'd0 : 32'd1);
    step(0, 1, add_i(20, 21, 22), '0, 1, 0, 0, 0, 0, 0);
    check("settle_pop", 32'(pop), 32'd0);
    step(0, 1, add_i(20, 21, 22), '0, 1, 1, 5, 0, 0, 0);
    check("settle_wb_pop", 32'(pop), 32'd0);
    step(0, 1, add_i(20, 21, 22), '0, 1, 0, 0, 0, 0, 0);
    check("settle_exit1_pop", 32'(pop), BYP ? 32'd1 : 32'd0);
    step(0, 1, add_i(20, 21, 22), '0, 1, 0, 0, 0, 0, 0);
    check("settle_exit2_pop", 32'(pop), BYP ? 32'd0 : 32'd1);
    step(1, 0, '0, '0, 1, 1, 20, 0, 0, 0);

    step(0, 0, add_i(3, 1, 2), add_i(9, 1, 2), 1, 0, 0, 0, 0, 0);
    check("pre_flush_pop", 32'(pop), 32'd2);
    step(0, 1, FENCE_I, '0, 1, 0, 0, 0, 0, 0);
    check("fence_drain_pop", 32'(pop), 32'd0);
    step(0, 1, FENCE_I, '0, 1, 1, 3, 0, 0, 1);
    check("flush_pop", 32'(pop), 32'd0);
    step(0, 0, add_i(3, 9, 1), add_i(12, 13, 14), 1, 0, 0, 0, 0, 0);
    check("post_flush_pop", 32'(pop), 32'd2);
    step(1, 0, '0, '0, 1, 1, 3, 1, 12, 0);

    step(0, 1, add_i(15, 0, 0), '0, 1, 0, 0, 0, 0, 0);
    check("x15_pop", 32'(pop), 32'd1);
    step(0, 1, ECALL_I, '0, 1, 0, 0, 0, 0, 0);
    force dut.stall_q = 32'hFFFF_FFFD;
    m_stall = 32'hFFFF_FFFD;
    #1;
    release dut.stall_q;
    repeat (4) step(0, 1, ECALL_I, '0, 1, 0, 0, 0, 0, 0);
    check("stall_saturated", stallCycles, 32'hFFFF_FFFF);

    step(0, 0, add_i(1, 2, 3), add_i(4, 5, 6), 1, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    #1;
    check("midreset_pop", 32'(pop), 32'd0);
    check("midreset_issueA", 32'(issueA), 32'd0);
    check("midreset_stall", stallCycles, 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    #2;
    check("after_reset_pop", 32'(pop), 32'd2);
    step(1, 0, '0, '0, 1, 1, 1, 1, 4, 0);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Dual-issue scheduler between the instruction buffer and the decode stage. Each cycle it inspects the two head instructions, checks them against a register scoreboard and against each other, and issues 0, 1 or 2 of them. It pops exactly the issued count from the buffer and serialises SYSTEM and MISC-MEM instructions with a drain/settle state machine. Busy bits are set on issue and cleared by writeback.

## Interface
- XLEN, 32, GPR width (32 or 64); carried only for package consistency, no datapath use
- NUM_REG, 32, number of GPRs (16 or 32); RIDX = $clog2(NUM_REG)
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous reset, active low
- flush  in  1  squash: clear scoreboard, no issue this cycle
- queueEmpty  in  1  buffer holds no instruction
- queueOne  in  1  buffer holds exactly one instruction (insB invalid)
- insA  in  32  head instruction
- insB  in  32  second instruction
- idReady  in  1  decode stage accepts issue this cycle
- wbA_en, wbB_en  in  1 each  writeback port valid
- wbA_rd, wbB_rd  in  RIDX each  writeback destination
- pop  out  2  instructions consumed this cycle (0, 1, 2)
- issueA, issueB  out  1 each  slot valid to decode (insA/insB pass through)
- stallCycles  out  32  saturating count of cycles with queue non-empty and pop==0

## Operation
- Field extraction (RV): rd = ins[11:7], rs1 = ins[19:15], rs2 = ins[24:20], truncated to RIDX; index 0 never tracked.
- hasRd: every opcode except STORE 0100011, BRANCH 1100011, MISC-MEM 0001111.
- usesRs1: every opcode except LUI 0110111, AUIPC 0010111, JAL 1101111.
- usesRs2: only OP 0110011, STORE, BRANCH.
- serial: SYSTEM 1110011 or MISC-MEM. ctrl: BRANCH, JAL, JALR 1100111.
- hazard(x): any used rs or tracked rd of x has busy bit set (RAW and WAW).
- States: RUN, DRAIN, SETTLE; reset to RUN.
- RUN, A non-serial: issueA = !queueEmpty & idReady & !hazard(A). issueB = issueA & !queueOne & !serial(B) & !ctrl(A) & !hazard(B) & B not dependent on A (B rs1/rs2/rd equals A's tracked rd).
- RUN, A serial: scoreboard empty & idReady -> issue A alone, go to SETTLE; otherwise go to DRAIN with no issue.
- DRAIN: no issue until scoreboard empty & idReady; then issue A alone, go to SETTLE.
- SETTLE: no issue; return to RUN once scoreboard empty.
- pop = issueA + issueB. issueB never asserts without issueA.
- Scoreboard: NUM_REG-1 busy bits. Issue sets the bit for each tracked rd; a writeback clears it. Same register set and cleared in one cycle: set wins.
- flush: highest priority. That cycle: pop = 0, issues = 0, all busy bits cleared (writebacks ignored), state -> RUN. stallCycles is not cleared.
- stallCycles increments when !flush & !queueEmpty & pop == 0; it saturates at all-ones.

## Timing
- Reset values: pop = 0, issueA/B = 0, stallCycles = 0, scoreboard clear, state RUN.
- issue/pop are combinational from the current inputs and registered state. Scoreboard, FSM and counter update on the rising edge.
- Writeback clear visible to the hazard check the next cycle (see Configuration).
- Reset asserted mid-drain: immediate return to reset values, with no pop.
- Minimum serial-instruction overhead: 1 SETTLE cycle.

## Configuration
- ISSUE_WB_BYPASS_EN defined: the hazard check uses busy & ~(same-cycle writeback clears), so a dependent instruction issues in the writeback cycle. The DRAIN/SETTLE emptiness test also uses the bypassed value.
- Undefined: the hazard check and emptiness test use registered busy bits only, adding one cycle of writeback-to-issue latency.

## Structure
- Shared package: opcode constants (OP, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM), FSM state enum, and a field-extraction/classification function set.
- Sub-module issue_scoreboard: busy bit vector, set/clear ports, bypass option, any-busy output.
- Sub-module hazard checks and the FSM live in issue_ctrl.

## Test plan
- Independent pair add x1,x2,x3 / add x4,x5,x6, idReady = 1, scoreboard clear -> issueA = issueB = 1, pop = 2, busy{x1,x4} set next cycle.
- Intra-pair RAW add x1.. / add x7,x1,x2 -> pop = 1. The next cycle B (now head) stalls until wbA_rd = 1 arrives. With the macro undefined it issues in the cycle after the writeback; with it defined, in the writeback cycle.
- csrrw x5 at head with x3 busy -> DRAIN, pop = 0, stallCycles increments. Writeback x3 -> issue csrrw alone and enter SETTLE. Writeback x5 -> RUN.
- Branch in A plus an independent B -> pop = 1. queueOne with an independent A -> pop = 1, issueB = 0.
- Flush during DRAIN with x3, x9 busy and a simultaneous wbA_rd = 3 -> pop = 0, all busy bits cleared, state RUN. A following independent pair issues with pop = 2.
- Hold stall beyond 2^32 cycles (force the counter near max) -> stallCycles stays 0xFFFFFFFF. Asserting resetn low mid-run -> all outputs 0 immediately.
